// File: rtl/flash_boot_pkg.sv
// Shared types and helpers for the boot flash arbiter and its byte sequencer.
package flash_boot_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        ACK
    } state_t;

    localparam logic [31:0] NOP_WORD = 32'h15000000;

    // Byte 0 lands in the most significant lane, so words assemble big-endian.
    function automatic logic [31:0] insert_byte(
        input logic [31:0] word,
        input logic [1:0]  idx,
        input logic [7:0]  data
    );
        logic [31:0] result;
        result = word;
        case (idx)
            2'd0:    result[31:24] = data;
            2'd1:    result[23:16] = data;
            2'd2:    result[15:8]  = data;
            default: result[7:0]   = data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/flash_byte_seq.sv
// Phase/byte counters for one four-byte flash read: ROM clock, byte index,
// per-byte sample strobe and a done strobe on the last phase of byte 3.
module flash_byte_seq import flash_boot_pkg::*; #(
    parameter int BYTE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       flash_clk,
    output logic [1:0] byte_idx,
    output logic       sample,
    output logic       done
);

    localparam int PW = $clog2(BYTE_CYCLES);
    localparam logic [PW-1:0] LAST_PHASE = PW'(BYTE_CYCLES - 1);
    localparam logic [PW-1:0] CLK_ON     = PW'(BYTE_CYCLES / 4);
    localparam logic [PW-1:0] CLK_OFF    = PW'((3 * BYTE_CYCLES) / 4);

    if (BYTE_CYCLES != 4 && BYTE_CYCLES != 8) begin : g_bad_byte_cycles
        $error("flash_byte_seq: BYTE_CYCLES must be 4 or 8");
    end

    logic [PW-1:0] phase;
    logic [PW-1:0] phase_next;
    logic [1:0]    byte_next;
    logic          busy;
    logic          busy_next;

    assign sample = busy && (phase == LAST_PHASE);
    assign done   = sample && (byte_idx == 2'd3);

    always_comb begin
        phase_next = phase;
        byte_next  = byte_idx;
        busy_next  = busy;
        if (start) begin
            phase_next = '0;
            byte_next  = 2'd0;
            busy_next  = 1'b1;
        end else if (busy) begin
            if (sample) begin
                phase_next = '0;
                if (byte_idx == 2'd3) begin
                    byte_next = 2'd0;
                    busy_next = 1'b0;
                end else begin
                    byte_next = byte_idx + 2'd1;
                end
            end else begin
                phase_next = phase + PW'(1);
            end
        end
    end

    // The ROM clock is registered from the next phase so it lines up with the
    // phase counter; the address only moves at phase 0 where it is always low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase     <= '0;
            byte_idx  <= 2'd0;
            busy      <= 1'b0;
            flash_clk <= 1'b0;
        end else begin
            phase     <= phase_next;
            byte_idx  <= byte_next;
            busy      <= busy_next;
            flash_clk <= busy_next && (phase_next >= CLK_ON) && (phase_next < CLK_OFF);
        end
    end

endmodule

// File: rtl/flash_boot_arb.sv
// Two-port Wishbone arbiter for the byte-wide boot flash: round-robin grant,
// one-word hit buffer, and big-endian reassembly of four byte reads.
module flash_boot_arb import flash_boot_pkg::*; #(
    parameter int          AW          = 5,
    parameter logic [31:0] NOP         = NOP_WORD,
    parameter int          BYTE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] m0_adr_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    output logic [31:0]   m0_dat_o,
    output logic          m0_ack_o,
    input  logic [AW-1:0] m1_adr_i,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    output logic [31:0]   m1_dat_o,
    output logic          m1_ack_o,
    output logic [AW+1:0] flash_addr_o,
    output logic          flash_clk_o,
    input  logic [7:0]    flash_dout_i
);

    state_t        state;
    logic          last_grant;
    logic          grant;
    logic [AW-1:0] adr_q;
    logic [AW-1:0] tag;
    logic          valid;
    logic [31:0]   dat;

    logic          req0;
    logic          req1;
    logic          any_req;
    logic          win;
    logic [AW-1:0] win_adr;
    logic          hit;
    logic          start_read;

    logic [1:0]    byte_idx;
    logic          sample;
    logic          done;

    // A tie goes to the port that did not win last time; the hit check uses
    // the winner's address so a hit never needs the flash.
    always_comb begin
        req0       = m0_cyc_i & m0_stb_i & ~m0_ack_o;
        req1       = m1_cyc_i & m1_stb_i & ~m1_ack_o;
        any_req    = req0 | req1;
        win        = (req0 & req1) ? ~last_grant : req1;
        win_adr    = win ? m1_adr_i : m0_adr_i;
        hit        = valid && (tag == win_adr);
        start_read = (state == IDLE) && any_req && !hit;
    end

    assign m0_dat_o     = dat;
    assign m1_dat_o     = dat;
    assign flash_addr_o = {adr_q, byte_idx};

    flash_byte_seq #(
        .BYTE_CYCLES(BYTE_CYCLES)
    ) u_seq (
        .clk      (clk),
        .rst      (rst),
        .start    (start_read),
        .flash_clk(flash_clk_o),
        .byte_idx (byte_idx),
        .sample   (sample),
        .done     (done)
    );

    // A master that drops its cycle mid-read still lets the read complete and
    // fill the buffer; it just gets no ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            adr_q      <= '0;
            tag        <= '0;
            valid      <= 1'b0;
            dat        <= NOP;
            m0_ack_o   <= 1'b0;
            m1_ack_o   <= 1'b0;
        end else begin
            m0_ack_o <= 1'b0;
            m1_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant      <= win;
                        last_grant <= win;
                        if (hit) begin
                            state    <= ACK;
                            m0_ack_o <= ~win;
                            m1_ack_o <= win;
                        end else begin
                            state <= READ;
                            adr_q <= win_adr;
                            valid <= 1'b0;
                        end
                    end
                end
                READ: begin
                    if (sample) begin
                        dat <= insert_byte(dat, byte_idx, flash_dout_i);
                    end
                    if (done) begin
                        valid    <= 1'b1;
                        tag      <= adr_q;
                        state    <= ACK;
                        m0_ack_o <= ~grant & m0_cyc_i & m0_stb_i;
                        m1_ack_o <= grant & m1_cyc_i & m1_stb_i;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
